// File: rtl/add_arbiter_12bit.sv
// Four requesters share one 12-bit ripple adder. A round-robin arbiter grants one
// operand pair per free cycle, and the sum is held in a registered output slot until it is consumed.

module add_12bit (
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  output logic [11:0] sum_o
);

  // Ripple-carry chain. Carry-in is tied to 0 and the final carry is dropped.
  always_comb begin
    logic carry_v;
    sum_o   = 12'h000;
    carry_v = 1'b0;
    for (int k = 0; k < 12; k++) begin
      sum_o[k] = a_i[k] ^ b_i[k] ^ carry_v;
      carry_v  = (a_i[k] & b_i[k]) | (carry_v & (a_i[k] ^ b_i[k]));
    end
  end

endmodule

module add_arbiter_12bit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_valid,
  input  logic [47:0]      req_no1,
  input  logic [47:0]      req_no2,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  output logic [11:0]      out_result,
  output logic [1:0]       out_id,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [11:0]      result_q, result_d;
  logic [1:0]       id_q, id_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             slot_free_s;
  logic             consume_s;
  logic             found_s;
  logic [1:0]       gidx_s;
  logic [3:0]       grant_s;
  logic [11:0]      opa_s;
  logic [11:0]      opb_s;
  logic [11:0]      sum_s;

  // A grant can only happen if the slot is empty, or if its content leaves this same cycle.
  assign consume_s   = (state_q == HOLD) && out_ready;
  assign slot_free_s = !rst && ((state_q == IDLE) || out_ready);

  // Round-robin search that starts just after the last granted requester.
  always_comb begin
    logic [1:0] idx_v;
    found_s = 1'b0;
    gidx_s  = 2'd0;
    grant_s = 4'b0000;
    idx_v   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx_v = last_q + 2'(k);
      if (!found_s && req_valid[idx_v]) begin
        found_s = 1'b1;
        gidx_s  = idx_v;
      end
    end
    if (slot_free_s && found_s) begin
      grant_s[gidx_s] = 1'b1;
    end else begin
      grant_s = 4'b0000;
    end
  end

  // Route the granted requester's operands into the shared adder.
  always_comb begin
    case (gidx_s)
      2'd0:    begin opa_s = req_no1[11:0];  opb_s = req_no2[11:0];  end
      2'd1:    begin opa_s = req_no1[23:12]; opb_s = req_no2[23:12]; end
      2'd2:    begin opa_s = req_no1[35:24]; opb_s = req_no2[35:24]; end
      2'd3:    begin opa_s = req_no1[47:36]; opb_s = req_no2[47:36]; end
      default: begin opa_s = 12'h000;        opb_s = 12'h000;        end
    endcase
  end

  add_12bit u_add (
    .a_i   (opa_s),
    .b_i   (opb_s),
    .sum_o (sum_s)
  );

  // Next-state logic. A new grant takes priority over emptying the slot.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    result_d = result_q;
    id_d     = id_q;
    count_d  = count_q;
    if (consume_s) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
    if (grant_s != 4'b0000) begin
      state_d  = HOLD;
      last_d   = gidx_s;
      result_d = sum_s;
      id_d     = gidx_s;
    end else if (consume_s) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 2'd3;
      result_q <= 12'h000;
      id_q     <= 2'd0;
      count_q  <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      result_q <= result_d;
      id_q     <= id_d;
      count_q  <= count_d;
    end
  end

  assign req_ready  = grant_s;
  assign out_valid  = (state_q == HOLD);
  assign out_result = result_q;
  assign out_id     = id_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_add_arbiter_12bit.sv
// Self-checking bench for add_arbiter_12bit: a table of directed cycles, randomized traffic
// compared against a behavioural model, and a counter-wrap check on a CNT_W=4 instance.

module tb_add_arbiter_12bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [47:0] req_no1;
  logic [47:0] req_no2;
  logic        out_ready;

  logic [3:0]  req_ready,  req_ready4;
  logic        out_valid,  out_valid4;
  logic [11:0] out_result, out_result4;
  logic [1:0]  out_id,     out_id4;
  logic [15:0] op_count;
  logic [3:0]  op_count4;

  always #5 clk = ~clk;

  add_arbiter_12bit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_no1(req_no1), .req_no2(req_no2),
    .req_ready(req_ready), .out_valid(out_valid), .out_result(out_result), .out_id(out_id),
    .out_ready(out_ready), .op_count(op_count)
  );

  add_arbiter_12bit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_no1(req_no1), .req_no2(req_no2),
    .req_ready(req_ready4), .out_valid(out_valid4), .out_result(out_result4), .out_id(out_id4),
    .out_ready(out_ready), .op_count(op_count4)
  );

  int tests  = 0;
  int failed = 0;

  // Reference model state, expressed in terms of the observable behaviour.
  bit       m_full;
  int       m_result;
  int       m_id;
  int       m_count;
  int       m_last;
  int       m_grant;
  logic [3:0] m_ready;

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic        ordy;
    logic [3:0]  e_ready;
    logic        e_valid;
    logic [11:0] e_result;
    logic [1:0]  e_id;
    logic [15:0] e_cnt;
  } vec_t;

  localparam logic [47:0] N1 = {12'hFFF, 12'h010, 12'h020, 12'h123};
  localparam logic [47:0] N2 = {12'h002, 12'h001, 12'h002, 12'h456};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, let them settle, and derive the model's grant for this cycle.
  task automatic drive(input logic r, input logic [3:0] rv, input logic [47:0] a,
                       input logic [47:0] b, input logic ordy);
    bit slot;
    rst = r; req_valid = rv; req_no1 = a; req_no2 = b; out_ready = ordy;
    #2;
    slot    = !r && (!m_full || ordy);
    m_grant = -1;
    if (slot) begin
      for (int k = 1; k <= 4; k++) begin
        if (m_grant < 0 && rv[(m_last + k) % 4]) m_grant = (m_last + k) % 4;
      end
    end
    m_ready = 4'b0000;
    if (m_grant >= 0) m_ready[m_grant] = 1'b1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ready"},  {28'd0, req_ready},   {28'd0, m_ready});
    chk({tag, "_valid"},  {31'd0, out_valid},   {31'd0, m_full});
    chk({tag, "_result"}, {20'd0, out_result},  m_result);
    chk({tag, "_id"},     {30'd0, out_id},      m_id);
    chk({tag, "_count"},  {16'd0, op_count},    m_count % 65536);
    chk({tag, "_count4"}, {28'd0, op_count4},   m_count % 16);
    chk({tag, "_ready4"}, {28'd0, req_ready4},  {28'd0, m_ready});
    chk({tag, "_result4"},{20'd0, out_result4}, m_result);
    chk({tag, "_valid4"}, {31'd0, out_valid4},  {31'd0, m_full});
    chk({tag, "_id4"},    {30'd0, out_id4},     m_id);
  endtask

  // Clock edge, then apply the specification's rules to the model.
  task automatic advance();
    @(posedge clk);
    #1;
    if (rst) begin
      m_full = 1'b0; m_result = 0; m_id = 0; m_count = 0; m_last = 3;
    end else begin
      if (m_full && out_ready) m_count++;
      if (m_grant >= 0) begin
        m_result = (int'(req_no1[12*m_grant +: 12]) + int'(req_no2[12*m_grant +: 12])) % 4096;
        m_id     = m_grant;
        m_last   = m_grant;
        m_full   = 1'b1;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
    end
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] rv, logic ordy, logic [3:0] er,
                              logic ev, logic [11:0] eres, logic [1:0] eid, logic [15:0] ec);
    vec_t v;
    v.rst = r; v.rv = rv; v.ordy = ordy; v.e_ready = er;
    v.e_valid = ev; v.e_result = eres; v.e_id = eid; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    // Fairness, back-to-back throughput, and overflow (FFF+002 -> 001 for requester 3).
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0001, 0, 12'h000, 2'd0, 16'd0));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 12'h579, 2'd0, 16'd0));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0100, 1, 12'h022, 2'd1, 16'd1));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b1000, 1, 12'h011, 2'd2, 16'd2));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 12'h001, 2'd3, 16'd3));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 12'h579, 2'd0, 16'd4));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 12'h579, 2'd0, 16'd5));
    // Backpressure: requester 1's result is held for five cycles, then consumed while it is re-granted.
    vecs.push_back(mk(0, 4'b0010, 1, 4'b0010, 0, 12'h579, 2'd0, 16'd5));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 4'b0010, 0, 4'b0000, 1, 12'h022, 2'd1, 16'd5));
    vecs.push_back(mk(0, 4'b0010, 1, 4'b0010, 1, 12'h022, 2'd1, 16'd5));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 12'h022, 2'd1, 16'd6));
    // Reset while HOLD, then the first grant goes to the lowest requesting index.
    vecs.push_back(mk(1, 4'b1000, 0, 4'b0000, 1, 12'h022, 2'd1, 16'd6));
    vecs.push_back(mk(0, 4'b1100, 1, 4'b0100, 0, 12'h000, 2'd0, 16'd0));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 12'h011, 2'd2, 16'd0));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 12'h011, 2'd2, 16'd1));

    m_full = 1'b0; m_result = 0; m_id = 0; m_count = 0; m_last = 3;

    // Reset, then check the reset state.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'b1111, N1, N2, 1'b1);
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      advance();
    end
    drive(1'b0, 4'b0000, N1, N2, 1'b0);
    check_model("reset");
    chk("reset_valid_const", {31'd0, out_valid}, 32'd0);
    chk("reset_cnt_const", {16'd0, op_count}, 32'd0);

    // Single request: 0x123 + 0x456.
    drive(1'b0, 4'b0001, N1, N2, 1'b1);
    chk("single_ready", {28'd0, req_ready}, 32'd1);
    advance();
    drive(1'b0, 4'b0000, N1, N2, 1'b1);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_result", {20'd0, out_result}, 32'h579);
    chk("single_id", {30'd0, out_id}, 32'd0);
    advance();
    drive(1'b0, 4'b0000, N1, N2, 1'b1);
    chk("single_count", {16'd0, op_count}, 32'd1);
    advance();
    // Re-reset so the table starts from last_grant = 3.
    drive(1'b1, 4'b0000, N1, N2, 1'b0);
    advance();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rv, N1, N2, vecs[i].ordy);
      chk($sformatf("vec%0d_ready", i),  {28'd0, req_ready},  {28'd0, vecs[i].e_ready});
      chk($sformatf("vec%0d_valid", i),  {31'd0, out_valid},  {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d_result", i), {20'd0, out_result}, {20'd0, vecs[i].e_result});
      chk($sformatf("vec%0d_id", i),     {30'd0, out_id},     {30'd0, vecs[i].e_id});
      chk($sformatf("vec%0d_cnt", i),    {16'd0, op_count},   {16'd0, vecs[i].e_cnt});
      advance();
    end

    // Randomized traffic against the model; operands change every cycle, including while a result is held.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0),
            4'($urandom_range(0, 15)),
            {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF,
            {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF,
            ($urandom_range(0, 9) < 7));
      check_model($sformatf("rnd%0d", i));
      advance();
    end

    // Counter wrap on the CNT_W=4 instance: 17 consumed results -> 1.
    drive(1'b1, 4'b0000, N1, N2, 1'b0);
    advance();
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 4'b0001, N1, N2, 1'b1);
      advance();
    end
    drive(1'b0, 4'b0000, N1, N2, 1'b1);
    advance();
    drive(1'b0, 4'b0000, N1, N2, 1'b1);
    chk("wrap_count4", {28'd0, op_count4}, 32'd1);
    chk("wrap_count16", {16'd0, op_count}, 32'd17);
    check_model("wrap");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/add_arbiter_12bit.md
ADD_ARBITER_12BIT -- requirements
Module: add_arbiter_12bit

Interface
REQ-001 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  4  per-requester operation request, bit i = requester i.
REQ-005 req_no1  input  48  packed first operands, requester i at bits [12i+11:12i].
REQ-006 req_no2  input  48  packed second operands, same packing as req_no1.
REQ-007 req_ready  output  4  one-hot grant; bit i high = requester i's operands accepted this cycle.
REQ-008 out_valid  output  1  out_result/out_id hold a completed sum.
REQ-009 out_result  output  12  registered sum, modulo 4096.
REQ-010 out_id  output  2  index of the requester that owns out_result.
REQ-011 out_ready  input  1  consumer accepts out_result when out_valid and out_ready are both high.
REQ-012 op_count  output  CNT_W  number of results consumed since reset.

Function
REQ-013 Block shall time-share one instance of the team's existing 12-bit ripple adder (add_12bit, carry-in 0, carry-out discarded) among the 4 requesters.
REQ-014 FSM states: IDLE (output register empty) and HOLD (output register full).
REQ-015 Slot free in a cycle = state IDLE, or state HOLD with out_ready high.
REQ-016 When slot free and req_valid nonzero, exactly one req_ready bit shall be high, chosen round-robin; otherwise req_ready shall be 0.
REQ-017 Round-robin: search starts at index (last_grant+1) mod 4, ascending with wrap; last_grant updates only on a grant.
REQ-018 req_ready shall be combinational from req_valid, state, out_ready and last_grant; no dependence of req_valid on req_ready is required.
REQ-019 On grant to i: at next edge out_result <= no1_i + no2_i (mod 4096), out_id <= i, state -> HOLD; latency one cycle from grant to out_valid.
REQ-020 HOLD with out_ready high and no request: state -> IDLE, out_valid falls next cycle.
REQ-021 HOLD with out_ready high and a grant in the same cycle: state stays HOLD, out_result/out_id replaced at next edge (back-to-back, one result per cycle).
REQ-022 HOLD with out_ready low: out_result, out_id, out_valid shall stay stable; req_ready = 0.
REQ-023 out_valid shall be high exactly in state HOLD.
REQ-024 op_count shall increment by 1 on each cycle with out_valid and out_ready high; wraps from 2^CNT_W-1 to 0.
REQ-025 Overflow: 12-bit sum wraps silently (e.g. 0xFFF+0x001 = 0x000); no flag.
REQ-026 Operands sampled only in the granted cycle; later changes of req_no1/req_no2 shall not affect a held result.
REQ-027 Throughput: with out_ready held high and requests pending, one grant per cycle.

Reset
REQ-028 With rst high at a rising edge: state -> IDLE, out_valid 0, out_result 0x000, out_id 0, op_count 0, last_grant 3 (so requester 0 wins first).
REQ-029 During a cycle with rst high, req_ready shall be 0.
REQ-030 Reset mid-operation (state HOLD) shall discard the held result with no consumption counted.

Verification
REQ-031 Single request: after reset, req_valid=0001, no1_0=0x123, no2_0=0x456, out_ready=1 -> req_ready=0001 that cycle; next cycle out_valid=1, out_result=0x579, out_id=0; op_count=1 after consumption.
REQ-032 Round-robin fairness: req_valid=1111 held, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; out_id sequence 0,1,2,3 with one-cycle lag.
REQ-033 Backpressure: result held with out_ready=0 for 5 cycles while req_valid=0010 -> req_ready=0, out_result/out_id unchanged, op_count unchanged; out_ready=1 -> consumed and requester 1 granted same cycle.
REQ-034 Overflow: no1=0xFFF, no2=0x002 -> out_result=0x001.
REQ-035 Reset in HOLD: rst pulsed while out_valid=1 -> next cycle out_valid=0, out_result=0x000, op_count=0; first grant after reset goes to lowest requesting index.
REQ-036 Counter wrap: CNT_W=4, 17 consumed results -> op_count=1.
